// File: rtl/capture_timestamp_ctrl.sv
// Timestamp capture controller: a start pulse arms a free-running counter, and
// capture pulses push the current count into a show-ahead FIFO with valid/ready drain.
module capture_timestamp_ctrl #(
  parameter int CNT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_an_i,
  input  logic                     rst_i,
  input  logic                     start_pulse_i,
  input  logic                     capture_pulse_i,
  input  logic                     rst_capture_pulse_i,
  output logic [CNT_W-1:0]         ts_data_o,
  output logic                     ts_valid_o,
  input  logic                     ts_ready_i,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     running_o,
  output logic                     wrap_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_C = CW'(DEPTH);

  typedef enum logic {IDLE, RUNNING} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             empty, full, pop, push_req, push;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wrap_d   = wrap_q;
    ovf_d    = ovf_q;
    data_d   = data_q;

    empty    = (count_q == '0);
    full     = (count_q == FULL_C);
    pop      = !empty && ts_ready_i && !rst_capture_pulse_i;
    push_req = capture_pulse_i && (state_q == RUNNING) && !rst_capture_pulse_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push     = push_req && (!full || pop);

    if (rst_capture_pulse_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wrap_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (start_pulse_i) begin
        state_d = RUNNING;
        cnt_d   = '0;
        wrap_d  = 1'b0;
      end else if (state_q == RUNNING) begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) wrap_d = 1'b1;
      end else begin
        cnt_d = '0;
      end

      if (push_req && full && !pop) ovf_d = 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);

      // Registered head: bypass the incoming value when it lands in the head slot
      if (count_d != '0) begin
        data_d = (push && (wr_ptr_q == rd_ptr_d)) ? cnt_q : mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wrap_q   <= 1'b0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
    end else if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wrap_q   <= 1'b0;
      ovf_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= cnt_q;
  end

  assign ts_data_o    = data_q;
  assign ts_valid_o   = (count_q != '0);
  assign fifo_count_o = count_q;
  assign running_o    = (state_q == RUNNING);
  assign wrap_o       = wrap_q;
  assign overflow_o   = ovf_q;

endmodule
